pixie_dp_front_end: RTL
=======================

// Module: pixie_dp_front_end
// PURPOSE
//  CDP1861-compatible PIXIE front end, dual-port memory version. Watches the 1802 bus
//  and generates INT, EFx and DMA-out requests. Writes each DMA-out byte into the write
//  port of the 1 KB dual-port frame buffer, which the back end reads for display.
//  Sits between the CPU bus decode and the frame buffer write port.
// PARAMETERS
//  cycles_per_line      14   machine cycles (TPB strobes) per scan line
//  lines_per_frame      262  scan lines per frame
//  display_start_line   64   first line that carries DMA display data
//  display_lines        128  number of DMA display lines (fb rows 0..127)
//  dma_first_cycle      2    first machine cycle of a line with DMA request asserted
//  bytes_per_line       8    DMA bytes accepted per display line
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  asynchronous active-low reset
//  tpb          in   1  one-clk strobe, end of each 1802 machine cycle
//  sc           in   2  1802 state code, sampled at tpb (2'b10 = DMA cycle)
//  data         in   8  1802 data bus, valid when tpb is high
//  disp_on      in   1  one-clk strobe, display enable (INP 1 decode)
//  disp_off     in   1  one-clk strobe, display disable (OUT 1 decode)
//  dma_out      out  1  DMA-out request to CPU, active high
//  int_req      out  1  interrupt request to CPU, active high
//  efx          out  1  EF flag to CPU, active high
//  fb_write_en  out  1  frame buffer write strobe, one clk
//  fb_addr      out  10 frame buffer address {row[6:0], byte[2:0]}
//  fb_data      out  8  frame buffer write data
// BEHAVIOUR
//  - Reset (async): all counters 0, enable 0; all outputs 0, including fb_addr and fb_data.
//  - cycle_ctr advances on tpb only: 0..cycles_per_line-1, then wraps to 0.
//    line_ctr increments when cycle_ctr wraps: 0..lines_per_frame-1, then wraps to 0.
//  - enable: set by disp_on, cleared by disp_off. If both arrive the same clk, off wins.
//  - active_line = display_start_line <= line_ctr < display_start_line+display_lines.
//    row = (line_ctr - display_start_line)[6:0].
//  - int_req = enable && line_ctr in [display_start_line-2, display_start_line-1].
//  - efx is independent of enable. It is high for line_ctr in [display_start_line-4,
//    display_start_line-1] and in [display_start_line+display_lines-4,
//    display_start_line+display_lines-1].
//  - dma_out = enable && active_line && cycle_ctr in [dma_first_cycle,
//    dma_first_cycle+bytes_per_line-1].
//  - byte_ctr (4 bit) clears whenever cycle_ctr wraps. It increments on each accepted
//    DMA cycle.
//  - Accept condition: tpb && sc==2'b10 && enable && active_line && byte_ctr<bytes_per_line.
//    The next clk gives fb_write_en=1, fb_addr={row, byte_ctr[2:0]} (pre-increment value),
//    fb_data=data. Latency is 1 clk. fb_write_en is 0 on every other clk.
//    fb_addr and fb_data hold their last values.
//  - Ignored DMA cycles (beyond 8 per line, outside active lines, or while disabled)
//    produce no write and do not change byte_ctr.
//  - All outputs are registered and update on clk. Changes to dma_out, int_req and efx
//    take effect 1 clk after the tpb that moves the counters.
//  - disp_off mid-line: dma_out drops the next clk and no further writes occur.
//    Counters keep running.
//  - disp_on mid-frame: DMA starts at the next qualifying cycle. It is not deferred
//    to a frame boundary.
//  - reset_n asserted mid-write: the write is dropped and the counters restart
//    at line 0, cycle 0.
// STRUCTURE
//  - Share pixie_timing.vh with pixie_dp_back_end. It holds the line/frame constants
//    and the frame buffer address width (10).
//  - One sub-module, pixie_line_timer: cycle_ctr/line_ctr with tpb advance,
//    exposing line_ctr, cycle_ctr and a line_wrap pulse. Decode and DMA capture
//    stay in the top module.
// TESTING
//  - Reset, then 262*14 tpb with enable=0 -> no fb_write_en, int_req and dma_out
//    stay 0, efx high on lines 60-63 and 188-191.
//  - disp_on, then run to line 64 with sc=2'b10 and data=8'hA0+i on cycles 2-9
//    -> 8 writes to fb_addr 10'h000-10'h007 with data A0-A7. dma_out is high
//    exactly on cycles 2-9. int_req is high on lines 62-63.
//  - Line 191 with 10 DMA cycles -> 8 writes at 10'h3F8-10'h3FF, then 2 ignored.
//    Line 192 produces no writes.
//  - disp_on and disp_off on the same clk -> enable stays 0. disp_off after 3 DMA
//    bytes on line 70 -> exactly 3 writes (addr 10'h030-10'h032), then dma_out=0.
//  - Assert reset_n low on the clk of an accepted DMA cycle -> no write. After
//    release, the line and cycle counters are 0 and all outputs are 0.

Source files
------------

// File: rtl/pixie_dp_front_end_pkg.sv
// Shared line/frame timing constants, frame buffer write payload and window decode
// helpers for the PIXIE dual-port front end.
package pixie_dp_front_end_pkg;

    localparam int unsigned CYCLES_PER_LINE    = 14;
    localparam int unsigned LINES_PER_FRAME    = 262;
    localparam int unsigned DISPLAY_START_LINE = 64;
    localparam int unsigned DISPLAY_LINES      = 128;
    localparam int unsigned DMA_FIRST_CYCLE    = 2;
    localparam int unsigned BYTES_PER_LINE     = 8;

    localparam int unsigned FB_ADDR_W = 10;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CYCLE_W   = 4;
    localparam int unsigned LINE_W    = 9;
    localparam int unsigned BYTE_W    = 4;
    localparam int unsigned ROW_W     = 7;
    localparam int unsigned COL_W     = 3;

    localparam logic [1:0] SC_DMA = 2'b10;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]    data;
    } fb_wr_t;

    function automatic logic line_in(input logic [LINE_W-1:0] line,
                                     input int unsigned lo, input int unsigned hi);
        return (line >= LINE_W'(lo)) && (line <= LINE_W'(hi));
    endfunction

    function automatic logic is_active_line(input logic [LINE_W-1:0] line);
        return line_in(line, DISPLAY_START_LINE, DISPLAY_START_LINE + DISPLAY_LINES - 1);
    endfunction

    function automatic logic in_dma_window(input logic [CYCLE_W-1:0] cycle);
        return (cycle >= CYCLE_W'(DMA_FIRST_CYCLE)) &&
               (cycle <= CYCLE_W'(DMA_FIRST_CYCLE + BYTES_PER_LINE - 1));
    endfunction

endpackage

// File: rtl/pixie_line_timer.sv
// Machine-cycle and scan-line counters advanced by TPB; also exposes the values the
// counters take this clk so the front end can register outputs without extra lag.
module pixie_line_timer
    import pixie_dp_front_end_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tpb_i,
    output logic [LINE_W-1:0]  line_o,
    output logic [CYCLE_W-1:0] cycle_nxt_c_o,
    output logic [LINE_W-1:0]  line_nxt_c_o,
    output logic               line_wrap_c_o
);

    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               cycle_last;
    logic               line_last;

    // Advance on TPB; cycle wrap steps the line, line wrap restarts the frame.
    always_comb begin
        cycle_d       = cycle_q;
        line_d        = line_q;
        cycle_last    = (cycle_q == CYCLE_W'(CYCLES_PER_LINE - 1));
        line_last     = (line_q == LINE_W'(LINES_PER_FRAME - 1));
        line_wrap_c_o = tpb_i && cycle_last;
        if (tpb_i) begin
            if (cycle_last) begin
                cycle_d = '0;
                line_d  = line_last ? '0 : line_q + LINE_W'(1);
            end else begin
                cycle_d = cycle_q + CYCLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
            line_q  <= '0;
        end else begin
            cycle_q <= cycle_d;
            line_q  <= line_d;
        end
    end

    assign line_o        = line_q;
    assign cycle_nxt_c_o = cycle_d;
    assign line_nxt_c_o  = line_d;

endmodule

// File: rtl/pixie_dp_front_end.sv
// CDP1861-style PIXIE front end: decodes INT/EFx/DMA-out from the scan timing and
// captures accepted DMA-out bytes into the dual-port frame buffer write port.
module pixie_dp_front_end
    import pixie_dp_front_end_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tpb,
    input  logic [1:0]           sc,
    input  logic [DATA_W-1:0]    data,
    input  logic                 disp_on,
    input  logic                 disp_off,
    output logic                 dma_out,
    output logic                 int_req,
    output logic                 efx,
    output logic                 fb_write_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0]    fb_data
);

    logic [LINE_W-1:0]  line_ctr;
    logic [CYCLE_W-1:0] cycle_nxt;
    logic [LINE_W-1:0]  line_nxt;
    logic               line_wrap;

    pixie_line_timer u_line_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .tpb_i         (tpb),
        .line_o        (line_ctr),
        .cycle_nxt_c_o (cycle_nxt),
        .line_nxt_c_o  (line_nxt),
        .line_wrap_c_o (line_wrap)
    );

    logic              enable_q, enable_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              dma_q, dma_d;
    logic              int_q, int_d;
    logic              efx_q, efx_d;
    logic              we_q, we_d;
    fb_wr_t            wr_q, wr_d;
    logic              accept_c;
    logic [ROW_W-1:0]  row_c;

    // Accept uses the pre-TPB counters and enable; decoded outputs use the post-TPB view.
    always_comb begin
        enable_d = enable_q;
        if (disp_off) begin
            enable_d = 1'b0;
        end else if (disp_on) begin
            enable_d = 1'b1;
        end

        row_c    = ROW_W'(line_ctr - LINE_W'(DISPLAY_START_LINE));
        accept_c = tpb && (sc == SC_DMA) && enable_q && is_active_line(line_ctr) &&
                   (byte_q < BYTE_W'(BYTES_PER_LINE));

        byte_d = byte_q;
        if (line_wrap) begin
            byte_d = '0;
        end else if (accept_c) begin
            byte_d = byte_q + BYTE_W'(1);
        end

        we_d = accept_c;
        wr_d = wr_q;
        if (accept_c) begin
            wr_d.addr = {row_c, byte_q[COL_W-1:0]};
            wr_d.data = data;
        end

        dma_d = enable_d && is_active_line(line_nxt) && in_dma_window(cycle_nxt);
        int_d = enable_d && line_in(line_nxt, DISPLAY_START_LINE - 2, DISPLAY_START_LINE - 1);
        efx_d = line_in(line_nxt, DISPLAY_START_LINE - 4, DISPLAY_START_LINE - 1) ||
                line_in(line_nxt, DISPLAY_START_LINE + DISPLAY_LINES - 4,
                        DISPLAY_START_LINE + DISPLAY_LINES - 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            byte_q   <= '0;
            dma_q    <= 1'b0;
            int_q    <= 1'b0;
            efx_q    <= 1'b0;
            we_q     <= 1'b0;
            wr_q     <= '0;
        end else begin
            enable_q <= enable_d;
            byte_q   <= byte_d;
            dma_q    <= dma_d;
            int_q    <= int_d;
            efx_q    <= efx_d;
            we_q     <= we_d;
            wr_q     <= wr_d;
        end
    end

    assign dma_out     = dma_q;
    assign int_req     = int_q;
    assign efx         = efx_q;
    assign fb_write_en = we_q;
    assign fb_addr     = wr_q.addr;
    assign fb_data     = wr_q.data;

endmodule
